spi_xfer_ctrl: RTL and testbench

SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

---
 rtl/spi_xfer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl -- 8-bit SPI master transfer engine behind a CSR block.
//
// A bus write to the data register starts one full-duplex byte transfer.
// Clock mode, bit order and SCK rate are latched at the start and held
// for the whole transfer.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   ctrl_enable, ctrl_master      transfers run only while both are 1
//   ctrl_dord                     0 = MSB first, 1 = LSB first
//   ctrl_mode[1:0]                {CPOL, CPHA}
//   ctrl_prescaler[1:0]           /4, /16, /64, /128
//   ctrl_clk2x                    halves the divisor
//   tx_wr, tx_wdata               data register write (starts a transfer)
//   rx_rd                         data register read (clears IF / WRCOL)
//   status_if_value               current status.if (becomes overrun bit)
//   status_if_next/_we            status.if hardware update
//   status_wrcol_next/_we         status.wrcol hardware update
//   data_rdata_next/_we           {overrun, rx byte} and its strobe
//   sck, mosi, ss_n, miso         SPI pins (miso already synchronised)
//   busy                          FSM is not idle
module spi_xfer_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       ctrl_enable,
    input  logic       ctrl_master,
    input  logic       ctrl_dord,
    input  logic [1:0] ctrl_mode,
    input  logic [1:0] ctrl_prescaler,
    input  logic       ctrl_clk2x,
    input  logic       tx_wr,
    input  logic [7:0] tx_wdata,
    input  logic       rx_rd,
    input  logic       status_if_value,
    output logic       status_if_next,
    output logic       status_if_we,
    output logic       status_wrcol_next,
    output logic       status_wrcol_we,
    output logic [8:0] data_rdata_next,
    output logic       data_rdata_we,
    output logic       sck,
    output logic       mosi,
    output logic       ss_n,
    input  logic       miso,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;

    state_t      state_q;
    logic [5:0]  hm1_d, hm1_q;      // half-period minus one
    logic [5:0]  cnt_q;             // cycles within the current half-period
    logic [4:0]  edge_q, edge_d;    // SCK edges issued so far (0..16)
    logic [7:0]  tx_q, rx_q;
    logic        cpol_q, cpha_q, dord_q;
    logic        sck_q, mosi_q, ss_n_q;
    logic        run_ok, sample_edge;
    logic        done_ok, wrcol_set;

    function automatic logic head(input logic [7:0] v, input logic lsb);
        return lsb ? v[0] : v[7];
    endfunction

    function automatic logic [7:0] advance(input logic [7:0] v, input logic lsb);
        return lsb ? {1'b0, v[7:1]} : {v[6:0], 1'b0};
    endfunction

    // Half-period table: (divisor >> clk2x) / 2, stored as H-1.
    always_comb begin
        case ({ctrl_clk2x, ctrl_prescaler})
            3'b000:  hm1_d = 6'd1;
            3'b001:  hm1_d = 6'd7;
            3'b010:  hm1_d = 6'd31;
            3'b011:  hm1_d = 6'd63;
            3'b100:  hm1_d = 6'd0;
            3'b101:  hm1_d = 6'd3;
            3'b110:  hm1_d = 6'd15;
            default: hm1_d = 6'd31;
        endcase
    end

    // Odd edges sample when CPHA=0; even edges sample when CPHA=1.
    always_comb begin
        edge_d      = edge_q + 5'd1;
        sample_edge = cpha_q ? ~edge_d[0] : edge_d[0];
        run_ok      = ctrl_enable & ctrl_master;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ss_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            hm1_q   <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            dord_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_wr && run_ok) begin
                        state_q <= SETUP;
                        ss_n_q  <= 1'b0;
                        sck_q   <= ctrl_mode[1];
                        cpol_q  <= ctrl_mode[1];
                        cpha_q  <= ctrl_mode[0];
                        dord_q  <= ctrl_dord;
                        hm1_q   <= hm1_d;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                        rx_q    <= '0;
                        // CPHA=0 drives the first bit before any SCK edge.
                        if (!ctrl_mode[0]) begin
                            mosi_q <= head(tx_wdata, ctrl_dord);
                            tx_q   <= advance(tx_wdata, ctrl_dord);
                        end else begin
                            tx_q   <= tx_wdata;
                        end
                    end
                end
                SETUP, XFER: begin
                    if (!run_ok) begin
                        state_q <= IDLE;
                        ss_n_q  <= 1'b1;
                        sck_q   <= cpol_q;
                    end else if (cnt_q != hm1_q) begin
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        cnt_q <= '0;
                        // After the 16th edge one more half-period elapses.
                        if (edge_q == 5'd16) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= XFER;
                            edge_q  <= edge_d;
                            sck_q   <= ~sck_q;
                            if (sample_edge) begin
                                rx_q <= dord_q ? {miso, rx_q[7:1]} : {rx_q[6:0], miso};
                            end else begin
                                mosi_q <= head(tx_q, dord_q);
                                tx_q   <= advance(tx_q, dord_q);
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ss_n_q  <= 1'b1;
                    sck_q   <= cpol_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // CSR strobes are decoded from the registered state; reset masks them.
    always_comb begin
        done_ok           = (state_q == DONE) & ~rst;
        wrcol_set         = tx_wr & (state_q != IDLE) & ~rst;
        status_if_we      = done_ok | (rx_rd & ~rst);
        status_if_next    = done_ok;            // DONE set beats rx_rd clear
        status_wrcol_we   = wrcol_set | (rx_rd & ~rst);
        status_wrcol_next = wrcol_set;
        data_rdata_we     = done_ok;
        data_rdata_next   = done_ok ? {status_if_value, rx_q} : '0;
    end

    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign ss_n = ss_n_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_enable = 1'b0, ctrl_master = 1'b0, ctrl_dord = 1'b0;
    logic [1:0] ctrl_mode = '0, ctrl_prescaler = '0;
    logic       ctrl_clk2x = 1'b0;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_wdata = '0;
    logic       rx_rd = 1'b0;
    logic       status_if_value = 1'b0;
    logic       status_if_next, status_if_we, status_wrcol_next, status_wrcol_we;
    logic [8:0] data_rdata_next;
    logic       data_rdata_we;
    logic       sck, mosi, ss_n, miso, busy;

    logic       miso_loop = 1'b1;
    logic       miso_val  = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    spi_xfer_ctrl dut (
        .clk(clk), .rst(rst),
        .ctrl_enable(ctrl_enable), .ctrl_master(ctrl_master), .ctrl_dord(ctrl_dord),
        .ctrl_mode(ctrl_mode), .ctrl_prescaler(ctrl_prescaler), .ctrl_clk2x(ctrl_clk2x),
        .tx_wr(tx_wr), .tx_wdata(tx_wdata), .rx_rd(rx_rd),
        .status_if_value(status_if_value),
        .status_if_next(status_if_next), .status_if_we(status_if_we),
        .status_wrcol_next(status_wrcol_next), .status_wrcol_we(status_wrcol_we),
        .data_rdata_next(data_rdata_next), .data_rdata_we(data_rdata_we),
        .sck(sck), .mosi(mosi), .ss_n(ss_n), .miso(miso), .busy(busy)
    );

    assign miso = miso_loop ? mosi : miso_val;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int half_period(input logic [1:0] p, input logic x2);
        int div;
        case (p)
            2'd0:    div = 4;
            2'd1:    div = 16;
            2'd2:    div = 64;
            default: div = 128;
        endcase
        return (div >> x2) / 2;
    endfunction

    // Reference model: transfer timeline derived from start cycle and H.
    initial begin : model
        int   rel, h;
        logic act, cpol_m, cpha_m, dord_m, idle_sck, csr_if;
        logic [7:0] txd, exp_rx;
        logic done, e_if_we, e_if_next, e_wc_we, e_wc_next, e_rd_we, e_sck;
        logic [8:0] e_rd;
        int   i, k;
        rel = 0; h = 1; act = 0; idle_sck = 0; csr_if = 0;
        cpol_m = 0; cpha_m = 0; dord_m = 0; txd = '0; exp_rx = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            done      = act && (rel == 1 + 17 * h);
            e_if_we   = !rst && (done || rx_rd);
            e_if_next = !rst && done;
            e_wc_next = !rst && tx_wr && act;
            e_wc_we   = e_wc_next || (!rst && rx_rd);
            e_rd_we   = !rst && done;
            e_rd      = e_rd_we ? {status_if_value, exp_rx} : 9'h000;
            if (act) begin
                i     = (rel - 1) / h;
                e_sck = cpol_m ^ ((i <= 15) && (i % 2 == 1));
            end else begin
                e_sck = idle_sck;
            end
            chk("ss_n", 36'(ss_n), 36'(!act));
            chk("busy", 36'(busy), 36'(act));
            chk("sck", 36'(sck), 36'(e_sck));
            chk("if_we", 36'(status_if_we), 36'(e_if_we));
            chk("if_next", 36'(status_if_next), 36'(e_if_next));
            chk("wrcol_we", 36'(status_wrcol_we), 36'(e_wc_we));
            chk("wrcol_next", 36'(status_wrcol_next), 36'(e_wc_next));
            chk("rdata_we", 36'(data_rdata_we), 36'(e_rd_we));
            chk("rdata_next", 36'(data_rdata_next), 36'(e_rd));
            // mosi must hold bit k on the cycle its sampling edge is issued
            if (act) begin
                k = -1;
                if (!cpha_m && (rel % (2 * h) == h) && rel <= 15 * h) k = (rel - h) / (2 * h);
                if (cpha_m && (rel % (2 * h) == 0) && rel >= 2 * h && rel <= 16 * h) k = rel / (2 * h) - 1;
                if (k >= 0) chk("mosi_bit", 36'(mosi), 36'(dord_m ? txd[k] : txd[7 - k]));
            end
            if (e_if_we) csr_if = e_if_next;
            if (rst) begin
                act = 0; idle_sck = 0;
            end else if (act) begin
                if (done || !(ctrl_enable && ctrl_master)) begin
                    act = 0; idle_sck = cpol_m;
                end else begin
                    rel++;
                end
            end else if (tx_wr && ctrl_enable && ctrl_master) begin
                act = 1; rel = 1;
                h = half_period(ctrl_prescaler, ctrl_clk2x);
                cpol_m = ctrl_mode[1]; cpha_m = ctrl_mode[0]; dord_m = ctrl_dord;
                txd = tx_wdata;
                exp_rx = miso_loop ? tx_wdata : {8{miso_val}};
            end
            @(posedge clk);
            #1 status_if_value = csr_if;
        end
    end

    task automatic cfg(input logic [1:0] mode, input logic dord, input logic [1:0] presc, input logic x2);
        ctrl_mode = mode; ctrl_dord = dord; ctrl_prescaler = presc; ctrl_clk2x = x2;
    endtask

    task automatic send(input logic [7:0] d, output int t);
        @(posedge clk); #1;
        tx_wr = 1'b1; tx_wdata = d; t = cyc;
        @(posedge clk); #1;
        tx_wr = 1'b0;
    endtask

    // Observe maxc cycles after a start at cycle t, injecting pulses by relative cycle.
    task automatic watch(input int t, input int h, input logic cpha, input int maxc,
                         input int coll_rel, input int rd_rel, input int drop_rel,
                         input int rst_rel, input int probe_rel,
                         output int done_rel, output logic [8:0] rd, output logic [35:0] scap,
                         output logic [7:0] mcap, output int wc_rel,
                         output logic [3:0] dflags, output logic [3:0] probe);
        int rel;
        done_rel = -1; wc_rel = -1; rd = '0; scap = '0; mcap = '0; dflags = '0; probe = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            rel = cyc - t;
            if (rel <= 36) scap = {scap[34:0], sck};
            if ((!cpha && (rel % (2 * h) == h) && rel <= 15 * h) ||
                (cpha && (rel % (2 * h) == 0) && rel >= 2 * h && rel <= 16 * h))
                mcap = {mcap[6:0], mosi};
            if (data_rdata_we && done_rel < 0) begin
                done_rel = rel;
                rd = data_rdata_next;
                dflags = {status_if_we, status_if_next, status_wrcol_we, status_wrcol_next};
            end
            if (status_wrcol_we && status_wrcol_next) wc_rel = rel;
            if (rel == probe_rel) probe = {ss_n, sck, mosi, busy};
            @(posedge clk); #1;
            rel = cyc - t;
            tx_wr = (rel == coll_rel);
            if (tx_wr) tx_wdata = 8'hFF;
            rx_rd = (rel == rd_rel);
            rst   = (rel == rst_rel);
            if (drop_rel > 0 && rel >= drop_rel) ctrl_enable = 1'b0;
        end
    endtask

    task automatic pulse_rd(output logic [3:0] f);
        @(posedge clk); #1 rx_rd = 1'b1;
        @(negedge clk);
        f = {status_if_we, status_if_next, status_wrcol_we, status_wrcol_next};
        @(posedge clk); #1 rx_rd = 1'b0;
    endtask

    initial begin : stim
        int t, dr, wc;
        logic [8:0] rd;
        logic [35:0] sc;
        logic [7:0] mc;
        logic [3:0] df, pr, f;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", 36'({ss_n, sck, mosi, busy}), 36'(4'b1000));
        chk("reset_we", 36'({status_if_we, status_wrcol_we, data_rdata_we}), 36'(3'b000));
        chk("reset_next", 36'({status_if_next, status_wrcol_next, data_rdata_next}), 36'(11'h000));
        rst = 1'b0;
        ctrl_enable = 1'b1; ctrl_master = 1'b1;

        // Mode 0, H=2, MSB first, loopback
        cfg(2'd0, 1'b0, 2'd0, 1'b0); miso_loop = 1'b1;
        send(8'hA5, t);
        watch(t, 2, 1'b0, 36, -1, -1, -1, -1, 36, dr, rd, sc, mc, wc, df, pr);
        chk("t1_done_rel", 36'(dr), 36'(35));
        chk("t1_rdata", 36'(rd), 36'(9'h0A5));
        chk("t1_sck_seq", sc, 36'h333333330);
        chk("t1_mosi_seq", 36'(mc), 36'(8'hA5));
        chk("t1_done_flags", 36'(df), 36'(4'b1100));
        chk("t1_after", 36'({pr[3], pr[2], pr[0]}), 36'(3'b100));
        pulse_rd(f);
        chk("rd_clear", 36'(f), 36'(4'b1010));

        // Mode 3, LSB first, H=32, miso held high
        cfg(2'd3, 1'b1, 2'd3, 1'b1); miso_loop = 1'b0; miso_val = 1'b1;
        send(8'h01, t);
        watch(t, 32, 1'b1, 546, -1, -1, -1, -1, 546, dr, rd, sc, mc, wc, df, pr);
        chk("t2_done_rel", 36'(dr), 36'(545));
        chk("t2_rdata", 36'(rd), 36'(9'h0FF));
        chk("t2_mosi_seq", 36'(mc), 36'(8'h80));
        chk("t2_after", 36'({pr[3], pr[2], pr[0]}), 36'(3'b110));

        // No read since t2: overrun; collision mid-transfer
        cfg(2'd0, 1'b0, 2'd0, 1'b0); miso_loop = 1'b1;
        send(8'h3C, t);
        watch(t, 2, 1'b0, 36, 10, -1, -1, -1, 36, dr, rd, sc, mc, wc, df, pr);
        chk("t3_done_rel", 36'(dr), 36'(35));
        chk("t3_rdata_ovr", 36'(rd), 36'(9'h13C));
        chk("t3_wrcol_rel", 36'(wc), 36'(10));
        chk("t3_mosi_seq", 36'(mc), 36'(8'h3C));
        pulse_rd(f);
        chk("rd_clear2", 36'(f), 36'(4'b1010));

        // Mode 1, LSB first, H=4, rx_rd coincident with DONE
        cfg(2'd1, 1'b1, 2'd1, 1'b1);
        send(8'h96, t);
        watch(t, 4, 1'b1, 70, -1, 69, -1, -1, 70, dr, rd, sc, mc, wc, df, pr);
        chk("t4_done_rel", 36'(dr), 36'(69));
        chk("t4_rdata", 36'(rd), 36'(9'h096));
        chk("t4_mosi_seq", 36'(mc), 36'(8'h69));
        chk("t4_set_wins", 36'(df), 36'(4'b1110));
        chk("t4_after", 36'({pr[3], pr[2], pr[0]}), 36'(3'b100));
        pulse_rd(f);

        // Write with master=0 is ignored
        ctrl_master = 1'b0;
        send(8'h55, t);
        watch(t, 2, 1'b0, 4, -1, -1, -1, -1, 3, dr, rd, sc, mc, wc, df, pr);
        chk("nomaster_idle", 36'({pr[3], pr[0]}), 36'(2'b10));
        chk("nomaster_nodone", 36'(dr), 36'(-1));
        ctrl_master = 1'b1;

        // Mode 2, H=8, enable dropped mid-XFER
        cfg(2'd2, 1'b0, 2'd1, 1'b0);
        send(8'hC3, t);
        watch(t, 8, 1'b0, 40, -1, -1, 30, -1, 31, dr, rd, sc, mc, wc, df, pr);
        chk("abort_pins", 36'({pr[3], pr[2], pr[0]}), 36'(3'b110));
        chk("abort_nodone", 36'(dr), 36'(-1));
        ctrl_enable = 1'b1;

        // Reset mid-XFER
        send(8'hC3, t);
        watch(t, 8, 1'b0, 45, -1, -1, -1, 40, 41, dr, rd, sc, mc, wc, df, pr);
        chk("rst_mid_pins", 36'(pr), 36'(4'b1000));
        chk("rst_mid_nodone", 36'(dr), 36'(-1));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1);
    end

endmodule
